// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: client/transmitter bus of the UART TX arbiter.
// master: en, req, req_data, tx_done driven toward the arbiter.
// slave: gnt, tx_start, tx_data, owner_id, busy, done_valid, err_timeout driven by the arbiter.
`timescale 1ns/1ps
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DATA_BITS = 3
);
  localparam int IW = $clog2(N_REQ);
  logic en;
  logic [N_REQ-1:0] req;
  logic [N_REQ*DATA_BITS-1:0] req_data;
  logic tx_done;
  logic [N_REQ-1:0] gnt;
  logic tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic [IW-1:0] owner_id;
  logic busy;
  logic done_valid;
  logic err_timeout;
  modport master (
    output en, req, req_data, tx_done,
    input gnt, tx_start, tx_data, owner_id, busy, done_valid, err_timeout
  );
  modport slave (
    input en, req, req_data, tx_done,
    output gnt, tx_start, tx_data, owner_id, busy, done_valid, err_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among N_REQ requesters.
// clk, rst_n (async, active-low); bus: slave side of uart_tx_arbiter_if.
`timescale 1ns/1ps
module uart_tx_arbiter #(
  parameter int DATA_BITS = 3,
  parameter int N_REQ = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input logic clk,
  input logic rst_n,
  uart_tx_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT_CYC);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] ptr, ptr_n, owner_q, owner_n, win;
  logic [CW-1:0] cnt, cnt_n;
  logic [N_REQ-1:0] gnt_q, gnt_n;
  logic [DATA_BITS-1:0] data_q, data_n;
  logic start_q, start_n, busy_q, busy_n, dv_q, dv_n, to_q, to_n, hit;
  assign bus.gnt = gnt_q;
  assign bus.tx_start = start_q;
  assign bus.tx_data = data_q;
  assign bus.owner_id = owner_q;
  assign bus.busy = busy_q;
  assign bus.done_valid = dv_q;
  assign bus.err_timeout = to_q;
  // ptr holds the highest-priority index for the next grant
  always_comb begin
    win = '0;
    hit = 1'b0;
    for (int i = 0; i < N_REQ; i++)
      if (!hit && bus.req[(int'(ptr) + i) % N_REQ]) begin
        win = IW'((int'(ptr) + i) % N_REQ);
        hit = 1'b1;
      end
  end
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    cnt_n = cnt;
    owner_n = owner_q;
    data_n = data_q;
    gnt_n = '0;
    start_n = 1'b0;
    busy_n = busy_q;
    dv_n = 1'b0;
    to_n = 1'b0;
    case (state)
      IDLE: if (bus.en && hit) begin
        state_n = ISSUE;
        owner_n = win;
        data_n = bus.req_data[int'(win)*DATA_BITS +: DATA_BITS];
        gnt_n = N_REQ'(1) << win;
        start_n = 1'b1;
        busy_n = 1'b1;
      end
      ISSUE: begin
        state_n = WAIT_DONE;
        ptr_n = (owner_q == IW'(N_REQ-1)) ? '0 : owner_q + IW'(1);
        cnt_n = '0;
      end
      WAIT_DONE: begin
        cnt_n = cnt + CW'(1);
        if (bus.tx_done || cnt == CW'(TIMEOUT_CYC-1)) begin
          state_n = IDLE;
          busy_n = 1'b0;
          dv_n = bus.tx_done;
          to_n = !bus.tx_done;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      owner_q <= '0;
      data_q <= '0;
      gnt_q <= '0;
      start_q <= 1'b0;
      busy_q <= 1'b0;
      dv_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
      owner_q <= owner_n;
      data_q <= data_n;
      gnt_q <= gnt_n;
      start_q <= start_n;
      busy_q <= busy_n;
      dv_q <= dv_n;
      to_q <= to_n;
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed vector and sequence checks of uart_tx_arbiter.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  uart_tx_arbiter_if #(.N_REQ(4), .DATA_BITS(3)) bus ();
  uart_tx_arbiter #(.DATA_BITS(3), .N_REQ(4), .TIMEOUT_CYC(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  typedef struct {
    logic en;
    logic [3:0] req;
    logic [11:0] rd;
    logic done;
    logic [12:0] exp;
  } vec_t;
  vec_t tv[14];
  function automatic logic [12:0] outs(logic [3:0] g, logic s, logic [2:0] d, logic [1:0] o,
                                       logic b, logic dv, logic to);
    return {g, s, d, o, b, dv, to};
  endfunction
  function automatic logic [12:0] obs();
    return {bus.gnt, bus.tx_start, bus.tx_data, bus.owner_id, bus.busy, bus.done_valid, bus.err_timeout};
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_start(string nm);
    int n = 0;
    while (!bus.tx_start && n < 10) begin
      step();
      n++;
    end
    chk({nm, "_start_seen"}, 32'(bus.tx_start), 32'd1);
  endtask
  task automatic done_pulse();
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
  endtask
  initial begin
    tv[0]  = '{1'b1, 4'b0000, 12'h000, 1'b0, outs(4'b0000, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0)};
    tv[1]  = '{1'b1, 4'b0100, 12'h140, 1'b0, outs(4'b0100, 1'b1, 3'b101, 2'd2, 1'b1, 1'b0, 1'b0)};
    tv[2]  = '{1'b1, 4'b0000, 12'h000, 1'b0, outs(4'b0000, 1'b0, 3'b101, 2'd2, 1'b1, 1'b0, 1'b0)};
    tv[3]  = '{1'b1, 4'b0000, 12'h000, 1'b0, outs(4'b0000, 1'b0, 3'b101, 2'd2, 1'b1, 1'b0, 1'b0)};
    tv[4]  = '{1'b1, 4'b0010, 12'h038, 1'b0, outs(4'b0000, 1'b0, 3'b101, 2'd2, 1'b1, 1'b0, 1'b0)};
    tv[5]  = '{1'b1, 4'b0000, 12'h000, 1'b1, outs(4'b0000, 1'b0, 3'b101, 2'd2, 1'b0, 1'b1, 1'b0)};
    tv[6]  = '{1'b1, 4'b0000, 12'h000, 1'b1, outs(4'b0000, 1'b0, 3'b101, 2'd2, 1'b0, 1'b0, 1'b0)};
    tv[7]  = '{1'b0, 4'b0011, 12'h01E, 1'b0, outs(4'b0000, 1'b0, 3'b101, 2'd2, 1'b0, 1'b0, 1'b0)};
    tv[8]  = '{1'b0, 4'b0011, 12'h01E, 1'b0, outs(4'b0000, 1'b0, 3'b101, 2'd2, 1'b0, 1'b0, 1'b0)};
    tv[9]  = '{1'b1, 4'b0011, 12'h01E, 1'b0, outs(4'b0001, 1'b1, 3'b110, 2'd0, 1'b1, 1'b0, 1'b0)};
    tv[10] = '{1'b0, 4'b0011, 12'h01E, 1'b0, outs(4'b0000, 1'b0, 3'b110, 2'd0, 1'b1, 1'b0, 1'b0)};
    tv[11] = '{1'b0, 4'b0011, 12'h01E, 1'b1, outs(4'b0000, 1'b0, 3'b110, 2'd0, 1'b0, 1'b1, 1'b0)};
    tv[12] = '{1'b0, 4'b0011, 12'h01E, 1'b0, outs(4'b0000, 1'b0, 3'b110, 2'd0, 1'b0, 1'b0, 1'b0)};
    tv[13] = '{1'b0, 4'b0011, 12'h01E, 1'b0, outs(4'b0000, 1'b0, 3'b110, 2'd0, 1'b0, 1'b0, 1'b0)};
    bus.en = 1'b0;
    bus.req = '0;
    bus.req_data = '0;
    bus.tx_done = 1'b0;
    step();
    step();
    chk("reset_state", 32'(obs()), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      bus.en = tv[i].en;
      bus.req = tv[i].req;
      bus.req_data = tv[i].rd;
      bus.tx_done = tv[i].done;
      step();
      chk($sformatf("vec%0d", i), 32'(obs()), 32'(tv[i].exp));
    end
    // round robin over all four requesters, fresh pointer
    bus.tx_done = 1'b0;
    bus.req = '0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.en = 1'b1;
    bus.req = 4'b1111;
    bus.req_data = {3'd4, 3'd3, 3'd2, 3'd1};
    for (int k = 0; k < 5; k++) begin
      wait_start($sformatf("rr%0d", k));
      chk($sformatf("rr%0d_owner", k), 32'(bus.owner_id), 32'(k % 4));
      chk($sformatf("rr%0d_gnt", k), 32'(bus.gnt), 32'(1 << (k % 4)));
      chk($sformatf("rr%0d_data", k), 32'(bus.tx_data), 32'(k % 4 + 1));
      repeat (4) step();
      done_pulse();
      chk($sformatf("rr%0d_done", k), 32'({bus.done_valid, bus.err_timeout, bus.busy}), 32'b100);
    end
    // watchdog expiry with no tx_done
    bus.req = '0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.req = 4'b0010;
    bus.req_data = 12'h028;
    wait_start("to");
    chk("to_data", 32'(bus.tx_data), 32'b101);
    bus.req = '0;
    step();
    begin
      int n = 0;
      while (!bus.err_timeout && n < 40) begin
        step();
        n++;
      end
      chk("to_cycles", 32'(n), 32'd16);
    end
    chk("to_flags", 32'({bus.err_timeout, bus.done_valid, bus.busy, bus.owner_id}), 32'b10001);
    // next request after a timeout, then tx_done on the expiry cycle
    bus.req = 4'b1000;
    bus.req_data = 12'h600;
    wait_start("after_to");
    chk("after_to_id", 32'({bus.owner_id, bus.tx_data}), 32'b11011);
    bus.req = '0;
    step();
    begin
      int errs = 0;
      for (int i = 0; i < 15; i++) begin
        step();
        errs += int'(bus.err_timeout) + int'(bus.done_valid);
      end
      chk("tie_quiet", 32'(errs), 32'd0);
    end
    done_pulse();
    chk("tie_done_wins", 32'({bus.done_valid, bus.err_timeout}), 32'b10);
    // asynchronous reset in WAIT_DONE
    bus.req = 4'b1000;
    wait_start("rst_frame");
    bus.req = '0;
    repeat (2) step();
    chk("rst_busy_before", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", 32'(obs()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.req = 4'b0110;
    bus.req_data = 12'h0A8;
    wait_start("post_rst");
    chk("post_rst_grant", 32'({bus.gnt, bus.owner_id, bus.tx_data}), 32'b0010_01_101);
    bus.req = '0;
    step();
    done_pulse();
    chk("post_rst_done", 32'({bus.done_valid, bus.owner_id}), 32'b101);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
